eight_bit_univ_sr: RTL and testbench
====================================

// Module: eight_bit_univ_sr
// PURPOSE
//   Universal shift register, 8 bits wide by default. Each clock it does one of:
//   hold, shift right, shift left, or parallel load, selected by s1/s0.
//   General-purpose datapath/serialiser primitive. Its output is the register itself.
// PARAMETERS
//   WIDTH  8  register width in bits; must be >= 2
// PORTS
//   clk                input   1      single clock; all state updates on rising edge
//   rst_n              input   1      asynchronous, active-low reset
//   s0                 input   1      mode select, low bit
//   s1                 input   1      mode select, high bit
//   parallel_in        input   WIDTH  data for parallel load
//   shift_left_input   input   1      serial in, enters bit 0 on left shift
//   shift_right_input  input   1      serial in, enters bit WIDTH-1 on right shift
//   out                output  WIDTH  register contents (registered, no comb path)
//   rotate             input   1      only when SR_ROTATE_EN is defined
// BEHAVIOUR
//   - rst_n low: out forced to 0 immediately, independent of clk.
//     It stays 0 while rst_n is low.
//   - rst_n released: first update occurs at the next rising clk edge.
//   - Mode {s1,s0}, sampled at the rising edge:
//       00 hold         out <= out
//       01 shift right  out <= {shift_right_input, out[WIDTH-1:1]}
//       10 shift left   out <= {out[WIDTH-2:0], shift_left_input}
//       11 load         out <= parallel_in
//   - Latency: exactly one edge; the new value is visible right after the edge.
//   - Repeated shifts are unbounded. Bits shifted out are discarded; there is no
//     saturation and no status output.
//   - Load has priority by encoding only. Any X/Z on s1/s0 is treated as hold.
//   - Reset asserted mid-operation wins over any mode in that cycle.
// CONFIGURATION
//   SR_ROTATE_EN defined:
//     - Adds input port rotate.
//     - rotate=1 in mode 01: out <= {out[0], out[WIDTH-1:1]}.
//     - rotate=1 in mode 10: out <= {out[WIDTH-2:0], out[WIDTH-1]}.
//     - rotate is ignored in modes 00 and 11.
//   SR_ROTATE_EN undefined:
//     - No rotate port.
//     - Serial inputs are always used, as in the table above.
// STRUCTURE
//   - Package eight_bit_univ_sr_pkg holds:
//       localparams MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11
//       typedef sr_mode_t (2-bit), built as {s1,s0}
//   - Sub-module sr_bit_cell: one flop plus a 4:1 mux.
//       inputs: mode, self, left neighbour, right neighbour, parallel bit
//       instantiated WIDTH times via generate
//   - Boundary neighbours are the serial inputs, or the wrap bits under SR_ROTATE_EN.
// TESTING
//   1 rst_n=0 with out=8'hA5 previously loaded, mid-cycle -> out=8'h00 at once,
//     before the next edge.
//   2 {s1,s0}=11, parallel_in=8'hFF, one edge -> out=8'hFF.
//   3 After 2: {s1,s0}=10, shift_left_input=0, three edges -> 8'hFE, 8'hFC, 8'hF8.
//   4 After 3: {s1,s0}=00, five edges -> out stays 8'hF8.
//     Then {s1,s0}=01, shift_right_input=1, one edge -> 8'hFC.
//   5 Load 8'h81, then {s1,s0}=10, shift_left_input=1, eight edges -> 8'hFF.
//     Next edge with shift_left_input=0 -> 8'hFE.
//   6 SR_ROTATE_EN, rotate=1: load 8'h81, {s1,s0}=01, one edge -> 8'hC0;
//     {s1,s0}=10, two edges -> 8'h81, then 8'h03.

Source files
------------

// File: rtl/eight_bit_univ_sr_pkg.sv
// Shared mode encodings for the universal shift register.
package eight_bit_univ_sr_pkg;

  typedef logic [1:0] sr_mode_t;

  localparam sr_mode_t MODE_HOLD = 2'b00;
  localparam sr_mode_t MODE_SHR  = 2'b01;
  localparam sr_mode_t MODE_SHL  = 2'b10;
  localparam sr_mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/eight_bit_univ_sr_bit_cell.sv
// One register bit: a flop fed by a 4:1 mux over hold / left / right / parallel.
module sr_bit_cell
  import eight_bit_univ_sr_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  sr_mode_t mode,
  input  logic     self_bit,
  input  logic     left_nb,
  input  logic     right_nb,
  input  logic     par_bit,
  output logic     q
);

  logic d;

  // Any unmatched mode (including X/Z in simulation) falls through to hold.
  always_comb begin
    d = self_bit;
    case (mode)
      MODE_SHR:  d = left_nb;
      MODE_SHL:  d = right_nb;
      MODE_LOAD: d = par_bit;
      default:   d = self_bit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

endmodule

// File: rtl/eight_bit_univ_sr.sv
// Universal shift register: hold / shift right / shift left / parallel load.
// Optional SR_ROTATE_EN adds a rotate input that wraps the boundary bits.
module eight_bit_univ_sr
  import eight_bit_univ_sr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             shift_left_input,
  input  logic             shift_right_input,
`ifdef SR_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] out
);

  sr_mode_t         mode;
  logic             msb_in;
  logic             lsb_in;
  logic [WIDTH-1:0] from_left;
  logic [WIDTH-1:0] from_right;

  assign mode = {s1, s0};

`ifdef SR_ROTATE_EN
  assign msb_in = rotate ? out[0]       : shift_right_input;
  assign lsb_in = rotate ? out[WIDTH-1] : shift_left_input;
`else
  assign msb_in = shift_right_input;
  assign lsb_in = shift_left_input;
`endif

  // Bit i's left neighbour is bit i+1 (used on shift right); right neighbour is bit i-1.
  assign from_left  = {msb_in, out[WIDTH-1:1]};
  assign from_right = {out[WIDTH-2:0], lsb_in};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_bit_cell u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .mode     (mode),
      .self_bit (out[i]),
      .left_nb  (from_left[i]),
      .right_nb (from_right[i]),
      .par_bit  (parallel_in[i]),
      .q        (out[i])
    );
  end

endmodule

// File: tb/tb_eight_bit_univ_sr.sv
// Self-checking bench for eight_bit_univ_sr: directed table, reset cases, random vs. model.
module tb_eight_bit_univ_sr;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s0, s1;
  logic [W-1:0] parallel_in;
  logic         shift_left_input, shift_right_input;
  logic         rotate;
  logic [W-1:0] out;

  int unsigned n_total  = 0;
  int unsigned n_passed = 0;

  eight_bit_univ_sr #(.WIDTH(W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s0                (s0),
    .s1                (s1),
    .parallel_in       (parallel_in),
    .shift_left_input  (shift_left_input),
    .shift_right_input (shift_right_input),
`ifdef SR_ROTATE_EN
    .rotate            (rotate),
`endif
    .out               (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   mode;
    logic [W-1:0] pin;
    logic         sli;
    logic         sri;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: out=%h expected=%h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] mode, input logic [W-1:0] pin,
                       input logic sli, input logic sri);
    {s1, s0}          = mode;
    parallel_in       = pin;
    shift_left_input  = sli;
    shift_right_input = sri;
  endtask

  // Inputs are changed 1 time unit after a rising edge; outputs sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: register treated as an integer value, modes as arithmetic ops.
  function automatic logic [W-1:0] model(input logic [W-1:0] v, input logic [1:0] mode,
                                         input logic [W-1:0] pin, input logic sli,
                                         input logic sri, input logic rot);
    int unsigned val, msb_bit, lsb_bit, mask;
    mask = (1 << W) - 1;
    val  = int'(v);
    msb_bit = rot ? (val % 2) : int'(sri);
    lsb_bit = rot ? (val >> (W - 1)) : int'(sli);
    case (mode)
      2'd1:    val = (val / 2) + msb_bit * (1 << (W - 1));
      2'd2:    val = ((val * 2) + lsb_bit) & mask;
      2'd3:    val = int'(pin);
      default: val = val;
    endcase
    return val[W-1:0];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] exp_v;
    logic [1:0]   m;
    logic [W-1:0] p;
    logic         a, b, r;

    rotate = 1'b0;
    drive(2'b00, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #12;
    check("reset_state", out, 8'h00);
    rst_n = 1'b1;
    #1;
    check("reset_release_no_edge", out, 8'h00);

    // Async reset mid-cycle with A5 held.
    tick();
    drive(2'b11, 8'hA5, 1'b0, 1'b0);
    tick();
    check("load_A5", out, 8'hA5);
    #2 rst_n = 1'b0;
    #1 check("async_reset_midcycle", out, 8'h00);
    drive(2'b11, 8'hFF, 1'b1, 1'b1);
    tick();
    check("reset_wins_over_load", out, 8'h00);
    #2 rst_n = 1'b1;
    #1 check("release_before_edge", out, 8'h00);
    tick();
    check("first_edge_after_release", out, 8'hFF);

    vq.push_back('{"load_FF",  2'b11, 8'hFF, 1'b0, 1'b0, 8'hFF});
    vq.push_back('{"shl_1",    2'b10, 8'h00, 1'b0, 1'b0, 8'hFE});
    vq.push_back('{"shl_2",    2'b10, 8'h00, 1'b0, 1'b0, 8'hFC});
    vq.push_back('{"shl_3",    2'b10, 8'h00, 1'b0, 1'b0, 8'hF8});
    for (int i = 0; i < 5; i++)
      vq.push_back('{"hold",   2'b00, 8'h3C, 1'b1, 1'b1, 8'hF8});
    vq.push_back('{"shr_1",    2'b01, 8'h00, 1'b0, 1'b1, 8'hFC});
    vq.push_back('{"load_81",  2'b11, 8'h81, 1'b0, 1'b0, 8'h81});
    vq.push_back('{"shl_in1",  2'b10, 8'h00, 1'b1, 1'b0, 8'h03});
    vq.push_back('{"shl_in1",  2'b10, 8'h00, 1'b1, 1'b0, 8'h07});
    vq.push_back('{"shl_in1",  2'b10, 8'h00, 1'b1, 1'b0, 8'h0F});
    vq.push_back('{"shl_in1",  2'b10, 8'h00, 1'b1, 1'b0, 8'h1F});
    vq.push_back('{"shl_in1",  2'b10, 8'h00, 1'b1, 1'b0, 8'h3F});
    vq.push_back('{"shl_in1",  2'b10, 8'h00, 1'b1, 1'b0, 8'h7F});
    vq.push_back('{"shl_in1",  2'b10, 8'h00, 1'b1, 1'b0, 8'hFF});
    vq.push_back('{"shl_in1",  2'b10, 8'h00, 1'b1, 1'b0, 8'hFF});
    vq.push_back('{"shl_in0",  2'b10, 8'h00, 1'b0, 1'b1, 8'hFE});
    vq.push_back('{"shr_in0",  2'b01, 8'h00, 1'b1, 1'b0, 8'h7F});

    foreach (vq[i]) begin
      drive(vq[i].mode, vq[i].pin, vq[i].sli, vq[i].sri);
      tick();
      check(vq[i].name, out, vq[i].exp);
    end

`ifdef SR_ROTATE_EN
    rotate = 1'b1;
    drive(2'b11, 8'h81, 1'b0, 1'b0);
    tick();
    check("rot_load_81", out, 8'h81);
    drive(2'b01, 8'h00, 1'b0, 1'b0);
    tick();
    check("rot_right", out, 8'hC0);
    drive(2'b10, 8'h00, 1'b0, 1'b0);
    tick();
    check("rot_left_1", out, 8'h81);
    tick();
    check("rot_left_2", out, 8'h03);
    rotate = 1'b0;
`endif

    // Random traffic with occasional mid-cycle async resets.
    exp_v = out;
    for (int i = 0; i < 400; i++) begin
      m = 2'($urandom_range(0, 3));
      p = W'($urandom);
      a = 1'($urandom);
      b = 1'($urandom);
`ifdef SR_ROTATE_EN
      r = 1'($urandom);
`else
      r = 1'b0;
`endif
      rotate = r;
      drive(m, p, a, b);
      if ($urandom_range(0, 31) == 0) begin
        #2 rst_n = 1'b0;
        #1 check("rand_async_reset", out, 8'h00);
        tick();
        rst_n = 1'b1;
        exp_v = '0;
        check("rand_reset_held", out, exp_v);
      end else begin
        exp_v = model(exp_v, m, p, a, b, r);
        tick();
        check("random", out, exp_v);
      end
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
